// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated frequency meter.
//   state_e     : measurement FSM states
//   SYNC_STAGES : depth of the input synchronizer ahead of the edge register
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous input into the CLK domain and flags its rising edges.
// Ports:
//   CLK      in   system clock, all logic on posedge
//   RST_N    in   asynchronous active-low reset
//   d_async  in   asynchronous input signal
//   rise     out  one-cycle pulse per rising edge of the synchronized input
module sync_edge_det
  import freq_meter_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d_async,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              edge_q;

  // sync_q[0] is the metastability-catching stage; only the last stage is used.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_async};
      edge_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~edge_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of an asynchronous signal over a window of
// GATE_CYCLES clock cycles, single-shot or back-to-back.
// Ports:
//   CLK         in   system clock
//   RST_N       in   asynchronous active-low reset
//   sig_in      in   measured signal, asynchronous to CLK
//   start       in   request a measurement (honoured in IDLE only)
//   cont        in   re-arm automatically after each result
//   busy        out  high while the gate window is open
//   done        out  one-cycle strobe, freq_count/overflow hold the new result
//   freq_count  out  edges counted in the last window (held)
//   overflow    out  last window saturated the edge counter (held)
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq_count,
  output logic             overflow
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GateLast = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  state_e           state_q, state_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, done_q;
  logic             rise;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .d_async (sig_in),
    .rise    (rise)
  );

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end
      end
      GATE: begin
        gate_cnt_d = gate_cnt_q + GW'(1);
        if (rise) begin
          if (edge_cnt_q == CntMax) begin
            sat_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end
        // Result is loaded on entry to LATCH so it is already valid while done is high;
        // the edge seen in the last gate cycle is included.
        if (gate_cnt_q == GateLast) begin
          state_d = LATCH;
          freq_d  = edge_cnt_d;
          ovf_d   = sat_d;
        end
      end
      LATCH: begin
        if (cont) begin
          state_d    = GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      // Decoded from next state so the outputs come straight from flops.
      busy_q     <= (state_d == GATE);
      done_q     <= (state_d == LATCH);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign freq_count = freq_q;
  assign overflow   = ovf_q;

endmodule
